// File: rtl/booth_pkg.sv
// Shared types and constants for the decimal operand entry path.
package booth_pkg;

  typedef enum logic [1:0] {
    EDIT,
    CONVERT,
    CHECK
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t MAX_DIGIT = 4'd9;

  // Smallest accumulator width that holds 10^digits - 1, i.e. ceil(log2(10^digits)).
  function automatic int unsigned acc_width(input int unsigned digits);
    int unsigned pow;
    int unsigned w;
    pow = 1;
    w   = 0;
    for (int unsigned i = 0; i < digits; i++) begin
      pow = pow * 10;
    end
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < pow) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  localparam int unsigned ACC_W_DEFAULT = acc_width(3);

endpackage

// File: rtl/entrada_decimal_antirrebote.sv
// Push-button conditioner: 2-FF synchroniser, stable-level debounce counter
// and a one-cycle pulse on each accepted 0->1 transition.
module antirrebote #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronise, count consecutive disagreeing cycles, accept and emit pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      pulse_q <= 1'b0;
      if (sync_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync_q;
          cnt_q   <= '0;
          pulse_q <= sync_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/entrada_decimal.sv
// Signed decimal operand entry: four debounced buttons edit sign + BCD digits,
// enter converts them by shift-add to two's complement and range-checks it.
module entrada_decimal
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DIGITS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_arriba,
  input  logic                  btn_siguiente,
  input  logic                  btn_signo,
  input  logic                  btn_enter,
  output logic [WIDTH-1:0]      operando,
  output logic                  valido,
  output logic                  error,
  output logic                  ocupado,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  signo,
  output logic [1:0]            cursor
);

  localparam int unsigned      ACC_W      = acc_width(DIGITS);
  localparam logic [31:0]      NEG_LIMIT  = 32'd1 << (WIDTH - 1);
  localparam logic [31:0]      POS_LIMIT  = NEG_LIMIT - 32'd1;
  localparam logic [1:0]       CURSOR_TOP = 2'(DIGITS - 1);

  logic p_arriba, p_siguiente, p_signo, p_enter;

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arriba (
    .clk(clk), .reset(reset), .btn_i(btn_arriba), .pulse_o(p_arriba));
  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_siguiente (
    .clk(clk), .reset(reset), .btn_i(btn_siguiente), .pulse_o(p_siguiente));
  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_signo (
    .clk(clk), .reset(reset), .btn_i(btn_signo), .pulse_o(p_signo));
  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .reset(reset), .btn_i(btn_enter), .pulse_o(p_enter));

  state_t           state_q;
  bcd_digit_t       digit_q [DIGITS];
  logic             signo_q;
  logic [1:0]       cursor_q;
  logic [1:0]       idx_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [WIDTH-1:0] operando_q;
  logic [WIDTH-1:0] magnitude;
  logic             valido_q;
  logic             error_q;
  logic             ocupado_q;
  logic             overflow;

  // Multiply-by-ten via shifts and fold in the current digit (MSD first).
  always_comb begin
    acc_d = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit_q[idx_q]);
  end

  // Range check against the signed limits; negative side allows one extra.
  always_comb begin
    overflow  = signo_q ? (32'(acc_q) > NEG_LIMIT) : (32'(acc_q) > POS_LIMIT);
    magnitude = WIDTH'(acc_q);
  end

  // Entry FSM: edits in EDIT, shift-add in CONVERT, range check in CHECK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EDIT;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        digit_q[i] <= '0;
      end
      signo_q    <= 1'b0;
      cursor_q   <= CURSOR_TOP;
      idx_q      <= '0;
      acc_q      <= '0;
      operando_q <= '0;
      valido_q   <= 1'b0;
      error_q    <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      valido_q <= 1'b0;
      case (state_q)
        EDIT: begin
          if (p_enter) begin
            error_q   <= 1'b0;
            acc_q     <= '0;
            idx_q     <= CURSOR_TOP;
            ocupado_q <= 1'b1;
            state_q   <= CONVERT;
          end else if (p_arriba) begin
            error_q <= 1'b0;
            digit_q[cursor_q] <= (digit_q[cursor_q] == MAX_DIGIT) ? '0
                                                                 : digit_q[cursor_q] + 4'd1;
          end else if (p_siguiente) begin
            error_q  <= 1'b0;
            cursor_q <= (cursor_q == '0) ? CURSOR_TOP : cursor_q - 2'd1;
          end else if (p_signo) begin
            error_q <= 1'b0;
            signo_q <= ~signo_q;
          end
        end
        CONVERT: begin
          acc_q <= acc_d;
          idx_q <= idx_q - 2'd1;
          if (idx_q == '0) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (overflow) begin
            error_q <= 1'b1;
          end else begin
            operando_q <= signo_q ? -magnitude : magnitude;
            valido_q   <= 1'b1;
          end
          ocupado_q <= 1'b0;
          state_q   <= EDIT;
        end
        default: begin
          ocupado_q <= 1'b0;
          state_q   <= EDIT;
        end
      endcase
    end
  end

  // Flatten digit registers for the display; units digit in the LSBs.
  always_comb begin
    bcd = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      bcd[4*i +: 4] = digit_q[i];
    end
  end

  assign operando = operando_q;
  assign valido   = valido_q;
  assign error    = error_q;
  assign ocupado  = ocupado_q;
  assign signo    = signo_q;
  assign cursor   = cursor_q;

endmodule

// File: tb/tb_entrada_decimal.sv
// Self-checking bench for entrada_decimal with a short debounce window.
module tb_entrada_decimal;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          btns;   // [0] arriba, [1] siguiente, [2] signo, [3] enter
  logic [WIDTH-1:0]    operando;
  logic                valido;
  logic                error;
  logic                ocupado;
  logic [4*DIGITS-1:0] bcd;
  logic                signo;
  logic [1:0]          cursor;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    bit               valid;
    logic [WIDTH-1:0] op;
  } exp_t;
  exp_t exp_q[$];

  entrada_decimal #(
    .WIDTH(WIDTH),
    .DIGITS(DIGITS),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_arriba(btns[0]),
    .btn_siguiente(btns[1]),
    .btn_signo(btns[2]),
    .btn_enter(btns[3]),
    .operando(operando),
    .valido(valido),
    .error(error),
    .ocupado(ocupado),
    .bcd(bcd),
    .signo(signo),
    .cursor(cursor)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Raise buttons m0 now and m2 two cycles later, release all after 10 cycles,
  // and record every valido pulse (count, cycle offset, operand) over 18 cycles.
  task automatic act(input logic [3:0] m0, input logic [3:0] m2,
                     output int vcount, output int vcyc, output logic [WIDTH-1:0] vop);
    int c0;
    vcount = 0;
    vcyc   = -1;
    vop    = '0;
    @(posedge clk);
    #1;
    btns = m0;
    c0   = cyc;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (valido) begin
        vcount++;
        vcyc = cyc - c0;
        vop  = operando;
      end
      if (cyc - c0 == 2) btns = btns | m2;
      if (cyc - c0 == 10) btns = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    btns  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (operando !== 8'h00) begin errors++; $display("FAIL reset_operando: got %h expected 00", operando); end
    checks++; if (valido !== 1'b0) begin errors++; $display("FAIL reset_valido: got %b expected 0", valido); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h expected 000", bcd); end
    checks++; if (signo !== 1'b0) begin errors++; $display("FAIL reset_signo: got %b expected 0", signo); end
    checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL reset_cursor: got %0d expected 2", cursor); end
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_convert_pos();
    int vc, vt;
    logic [WIDTH-1:0] vo;
    exp_t e;
    act(4'b0001, 4'b0000, vc, vt, vo);                 // d2 = 1
    act(4'b0010, 4'b0000, vc, vt, vo);                 // cursor 1
    for (int i = 0; i < 2; i++) act(4'b0001, 4'b0000, vc, vt, vo);
    act(4'b0010, 4'b0000, vc, vt, vo);                 // cursor 0
    for (int i = 0; i < 3; i++) act(4'b0001, 4'b0000, vc, vt, vo);
    checks++; if (bcd !== 12'h123) begin errors++; $display("FAIL pos_bcd: got %h expected 123", bcd); end
    checks++; if (cursor !== 2'd0) begin errors++; $display("FAIL pos_cursor: got %0d expected 0", cursor); end
    exp_q.push_back('{1'b1, 8'h7B});
    act(4'b1000, 4'b0000, vc, vt, vo);
    e = exp_q.pop_front();
    checks++; if (vc != (e.valid ? 1 : 0)) begin errors++; $display("FAIL pos_valido_count: got %0d expected %0d", vc, e.valid ? 1 : 0); end
    if (e.valid) begin
      checks++; if (vo !== e.op) begin errors++; $display("FAIL pos_operando: got %h expected %h", vo, e.op); end
      checks++; if (vt != 11) begin errors++; $display("FAIL pos_latency: got %0d expected 11", vt); end
    end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL pos_error: got %b expected 0", error); end
    checks++; if (bcd !== 12'h123) begin errors++; $display("FAIL pos_retained: got %h expected 123", bcd); end
  endtask

  task automatic test_convert_neg();
    int vc, vt;
    logic [WIDTH-1:0] vo;
    exp_t e;
    for (int i = 0; i < 5; i++) act(4'b0001, 4'b0000, vc, vt, vo);
    checks++; if (bcd !== 12'h128) begin errors++; $display("FAIL ovf_bcd: got %h expected 128", bcd); end
    // +128 is out of range
    exp_q.push_back('{1'b0, 8'h00});
    act(4'b1000, 4'b0000, vc, vt, vo);
    e = exp_q.pop_front();
    checks++; if (vc != (e.valid ? 1 : 0)) begin errors++; $display("FAIL ovf_valido_count: got %0d expected %0d", vc, e.valid ? 1 : 0); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error: got %b expected 1", error); end
    checks++; if (operando !== 8'h7B) begin errors++; $display("FAIL ovf_operando_kept: got %h expected 7b", operando); end
    act(4'b0100, 4'b0000, vc, vt, vo);
    checks++; if (signo !== 1'b1) begin errors++; $display("FAIL neg_signo: got %b expected 1", signo); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL neg_error_cleared: got %b expected 0", error); end
    // -128 is the most negative legal value
    exp_q.push_back('{1'b1, 8'h80});
    act(4'b1000, 4'b0000, vc, vt, vo);
    e = exp_q.pop_front();
    checks++; if (vc != (e.valid ? 1 : 0)) begin errors++; $display("FAIL neg_valido_count: got %0d expected %0d", vc, e.valid ? 1 : 0); end
    if (e.valid) begin
      checks++; if (vo !== e.op) begin errors++; $display("FAIL neg_operando: got %h expected %h", vo, e.op); end
      checks++; if (vt != 11) begin errors++; $display("FAIL neg_latency: got %0d expected 11", vt); end
    end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL neg_error: got %b expected 0", error); end
    act(4'b0100, 4'b0000, vc, vt, vo);                 // back to positive
  endtask

  task automatic test_bounce();
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      btns[0] = (i % 2 == 0);
      repeat (2) @(posedge clk);
      #1;
    end
    btns[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    btns[0] = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++; if (bcd !== 12'h129) begin errors++; $display("FAIL bounce_bcd: got %h expected 129", bcd); end
  endtask

  task automatic test_wrap();
    int vc, vt;
    logic [WIDTH-1:0] vo;
    act(4'b0001, 4'b0000, vc, vt, vo);                 // 9 -> 0
    checks++; if (bcd !== 12'h120) begin errors++; $display("FAIL wrap_9to0: got %h expected 120", bcd); end
    for (int i = 0; i < 10; i++) act(4'b0001, 4'b0000, vc, vt, vo);
    checks++; if (bcd !== 12'h120) begin errors++; $display("FAIL wrap_10press: got %h expected 120", bcd); end
    act(4'b0010, 4'b0000, vc, vt, vo);                 // 0 -> 2
    checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL cursor_wrap: got %0d expected 2", cursor); end
    act(4'b0010, 4'b0000, vc, vt, vo);
    checks++; if (cursor !== 2'd1) begin errors++; $display("FAIL cursor_step: got %0d expected 1", cursor); end
    for (int i = 0; i < 2; i++) act(4'b0010, 4'b0000, vc, vt, vo);
    checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL cursor_3press: got %0d expected 2", cursor); end
  endtask

  task automatic test_simultaneous();
    int vc, vt;
    logic [WIDTH-1:0] vo;
    exp_t e;
    exp_q.push_back('{1'b1, 8'h78});
    act(4'b1001, 4'b0000, vc, vt, vo);                 // enter + arriba together
    e = exp_q.pop_front();
    checks++; if (vc != (e.valid ? 1 : 0)) begin errors++; $display("FAIL simul_valido_count: got %0d expected %0d", vc, e.valid ? 1 : 0); end
    if (e.valid) begin
      checks++; if (vo !== e.op) begin errors++; $display("FAIL simul_operando: got %h expected %h", vo, e.op); end
    end
    checks++; if (bcd !== 12'h120) begin errors++; $display("FAIL simul_bcd: got %h expected 120", bcd); end
  endtask

  task automatic test_back_to_back();
    int vc, vt;
    logic [WIDTH-1:0] vo;
    exp_t e;
    exp_q.push_back('{1'b1, 8'h78});
    act(4'b1000, 4'b0001, vc, vt, vo);                 // arriba lands while busy
    e = exp_q.pop_front();
    checks++; if (vc != (e.valid ? 1 : 0)) begin errors++; $display("FAIL busy_valido_count: got %0d expected %0d", vc, e.valid ? 1 : 0); end
    if (e.valid) begin
      checks++; if (vo !== e.op) begin errors++; $display("FAIL busy_operando: got %h expected %h", vo, e.op); end
      checks++; if (vt != 11) begin errors++; $display("FAIL busy_latency: got %0d expected 11", vt); end
    end
    checks++; if (bcd !== 12'h120) begin errors++; $display("FAIL busy_bcd: got %h expected 120", bcd); end
  endtask

  task automatic test_reset_mid();
    int vc, vt;
    bit seen;
    logic [WIDTH-1:0] vo;
    seen = 1'b0;
    @(posedge clk);
    #1;
    btns = 4'b1000;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ocupado) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_busy_timeout: got ocupado 0 expected 1 within 20 cycles"); end
    reset = 1'b0;
    btns  = '0;
    #1;
    checks++; if (operando !== 8'h00) begin errors++; $display("FAIL rmid_operando: got %h expected 00", operando); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL rmid_ocupado: got %b expected 0", ocupado); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL rmid_bcd: got %h expected 000", bcd); end
    checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL rmid_cursor: got %0d expected 2", cursor); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    vc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (valido || ocupado) vc++;
    end
    checks++; if (vc != 0) begin errors++; $display("FAIL rmid_activity: got %0d cycles of valido/ocupado expected 0", vc); end
    act(4'b0001, 4'b0000, vc, vt, vo);
    checks++; if (bcd !== 12'h100) begin errors++; $display("FAIL rmid_edit: got %h expected 100", bcd); end
  endtask

  initial begin
    btns  = '0;
    reset = 1'b0;
    test_reset();
    test_convert_pos();
    test_convert_neg();
    test_bounce();
    test_wrap();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
